// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types and default sizes for the pipe_MIPS32 memory arbiter.
// Imported by the interface, the grant picker and the arbiter top.
package mips_mem_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Bits needed to hold a counter that saturates at max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Pipeline-side request/response signals and memory-side bus of the arbiter.
// slave is the arbiter's view; master is the view of the surrounding system.
interface mips_mem_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              halted;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              busy;

    modport slave (
        input  halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mips_mem_arbiter_pick.sv
// Data-priority grant pick with a saturating starvation counter that forces
// an instruction fetch after STARVE_MAX back-to-back data grants.
module mips_arb_pick
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic grant_en,
    input  logic if_req,
    input  logic dm_req,
    input  logic halted,
    output logic grant_if,
    output logic grant_dm
);

    localparam int CW = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_r;
    logic [CW-1:0] starve_cnt_s;

    // Grant decision: data wins unless IF has waited out its starvation budget.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (grant_en) begin
            if (dm_req && ((starve_cnt_r < MAX_C) || !if_req || halted)) begin
                grant_dm = 1'b1;
            end else if (if_req && !halted) begin
                grant_if = 1'b1;
            end else begin
                grant_dm = 1'b0;
            end
        end else begin
            grant_if = 1'b0;
        end
    end

    // Starvation count: rises only while an unhalted fetch is being passed over.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (grant_if) begin
            starve_cnt_s = {CW{1'b0}};
        end else if (grant_dm) begin
            if (!if_req) begin
                starve_cnt_s = {CW{1'b0}};
            end else if (halted) begin
                starve_cnt_s = starve_cnt_r;
            end else if (starve_cnt_r < MAX_C) begin
                starve_cnt_s = starve_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                starve_cnt_s = starve_cnt_r;
            end
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CW{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_s;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between pipe_MIPS32 fetch and MEM-stage ports.
// One access in flight: IDLE (grant) -> BUSY (wait mem_ack) -> RESP (rvalid).
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    mips_mem_arbiter_if.slave      bus
);

    state_t            state_r;
    state_t            state_s;
    owner_t            owner_r;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              mem_req_r;
    logic              mem_req_s;
    logic              if_rvalid_r;
    logic              if_rvalid_s;
    logic              dm_rvalid_r;
    logic              dm_rvalid_s;
    logic              busy_r;
    logic              busy_s;
    logic              grant_en_s;
    logic              grant_if_s;
    logic              grant_dm_s;
    logic              grant_any_s;

    // Grants are suppressed while reset is held so every output reads 0.
    assign grant_en_s  = (state_r == IDLE) && rst_n;
    assign grant_any_s = grant_if_s || grant_dm_s;

    mips_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .grant_en (grant_en_s),
        .if_req   (bus.if_req),
        .dm_req   (bus.dm_req),
        .halted   (bus.halted),
        .grant_if (grant_if_s),
        .grant_dm (grant_dm_s)
    );

    // Next state and next values of the registered handshake outputs.
    always_comb begin
        state_s     = state_r;
        mem_req_s   = 1'b0;
        if_rvalid_s = 1'b0;
        dm_rvalid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    state_s   = BUSY;
                    mem_req_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_s     = RESP;
                    if_rvalid_s = (owner_r == OWN_IF);
                    dm_rvalid_s = (owner_r == OWN_DM);
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // FSM state and registered strobes.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            mem_req_r   <= mem_req_s;
            if_rvalid_r <= if_rvalid_s;
            dm_rvalid_r <= dm_rvalid_s;
            busy_r      <= busy_s;
        end
    end

    // Request capture on grant and response capture on memory acknowledge.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            owner_r    <= OWN_IF;
            addr_r     <= {ADDR_W{1'b0}};
            we_r       <= 1'b0;
            wdata_r    <= {DATA_W{1'b0}};
            if_rdata_r <= {DATA_W{1'b0}};
            dm_rdata_r <= {DATA_W{1'b0}};
        end else if ((state_r == IDLE) && grant_any_s) begin
            owner_r <= grant_dm_s ? OWN_DM : OWN_IF;
            addr_r  <= grant_dm_s ? bus.dm_addr : bus.if_addr;
            we_r    <= grant_dm_s && bus.dm_we;
            wdata_r <= grant_dm_s ? bus.dm_wdata : {DATA_W{1'b0}};
        end else if ((state_r == BUSY) && bus.mem_ack) begin
            // Write enable drops together with mem_req at the end of the access.
            we_r <= 1'b0;
            if (owner_r == OWN_IF) begin
                if_rdata_r <= bus.mem_rdata;
            end else begin
                dm_rdata_r <= we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
            end
        end else begin
            owner_r <= owner_r;
            addr_r  <= addr_r;
        end
    end

    assign bus.if_gnt    = grant_if_s;
    assign bus.dm_gnt    = grant_dm_s;
    assign bus.if_rvalid = if_rvalid_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rvalid = dm_rvalid_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.busy      = busy_r;

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the single-port word-addressed memory of pipe_MIPS32 between the instruction-fetch port (IF) and the data port (MEM stage: LW/SW).
- Fixed data-priority arbitration with a starvation guard for IF.
- One transfer in flight at a time; memory latency is variable and signalled by mem_ack.
- Sits between the pipeline stages and the memory array.

Parameters:
- ADDR_W, 10, word-address width (1024-word memory).
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before IF is forced.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- halted  in  1  pipeline HALTED flag; blocks new IF grants.
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse, if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- dm_req  in  1  data request, held until dm_gnt.
- dm_we  in  1  1 = store (SW), 0 = load (LW).
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data accepted this cycle (combinational).
- dm_rvalid  out  1  one-cycle pulse; load data or store completion.
- dm_rdata  out  DATA_W  load data; 0 for stores.
- mem_req  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  access complete.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, starve_cnt 0, owner IF. Reset is asynchronous and may occur mid-transfer. It drops the transfer: no rvalid is produced and requesters reissue.
- States:
  - IDLE: the grant decision is made this cycle.
  - BUSY: mem_req=1, with latched owner/addr/we/wdata held stable.
  - RESP: rvalid pulse.
- Grant in IDLE (combinational on registered state):
  - dm_req && (starve_cnt < STARVE_MAX || !if_req || halted) -> dm_gnt.
  - else if_req && !halted -> if_gnt.
  - else nothing.
- The grant cycle latches the request fields and moves to BUSY. At most one gnt is asserted per cycle.
- starve_cnt:
  - +1 on a data grant while if_req && !halted, saturating at STARVE_MAX.
  - Cleared on an IF grant, and on a data grant with if_req low.
  - Held while halted.
- BUSY: wait for mem_ack. On ack, register mem_rdata (or 0 if the access is a write) into the owner's rdata and go to RESP.
- RESP: the owner's rvalid=1 for exactly one cycle, then IDLE.
- Latency: grant at cycle N, mem_req from N+1, rvalid at ack_cycle+1. The minimum is rvalid at N+2 when memory acks in the first BUSY cycle. Throughput is one access per 3 cycles minimum.
- if_rdata/dm_rdata hold their last value between pulses.
- mem_ack while in IDLE or RESP is ignored.
- Request signals changing during BUSY have no effect; the latched copy is used.
- halted rising while an IF access is in BUSY: that access completes normally.
- mem_we is only ever 1 for a data-owner write.

Decomposition:
- Package mips_mem_pkg:
  - state enum {IDLE, BUSY, RESP};
  - owner enum {OWN_IF, OWN_DM};
  - default widths.
- Sub-module mips_arb_pick: combinational grant pick plus the saturating starve_cnt register. Inputs are the reqs, halted and a grant strobe. Outputs are grant_if and grant_dm.

Test Plan:
- IF only, if_addr=5, mem_rdata=32'h14431000, ack after 1 cycle -> if_gnt at N, mem_req at N+1, if_rvalid at N+2 with if_rdata=32'h14431000, busy back to 0 at N+3.
- Store: dm_we=1, dm_addr=198, dm_wdata=5040, ack after 3 cycles -> mem_we=1, mem_addr=198, mem_wdata=5040 held stable for 3 cycles; dm_rvalid pulse with dm_rdata=0; if_rvalid never asserted.
- Both held continuously, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM,...; starve_cnt returns to 0 after the IF grant.
- halted=1 with if_req and dm_req held -> only dm grants, no if_gnt; deassert halted -> IF is granted per the starve_cnt rule.
- Load from dm_addr=200 with mem_rdata=7; assert rst_n=0 during BUSY -> all outputs 0 immediately, no dm_rvalid; after release the reissued load returns dm_rdata=7.
- Spurious mem_ack in IDLE, and if_addr changed during BUSY -> no rvalid from the spurious ack; mem_addr keeps the originally latched address.
